scan_test_ctrl: RTL and testbench

- Scan-test sequencer that sits directly upstream of alu_scan and drives its scan_en and scan_in.
- Consumes alu_scan's scan_out: shifts a stimulus pattern into the chain, then runs functional capture cycles.
- Unloads the response and compares it with an expected vector.
- Reports done/pass for one pattern per start request.

---
 rtl/scan_test_ctrl_if.sv | 27 ++
 rtl/scan_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_scan_test_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_test_ctrl_if.sv
// Host/chain-side bundle for scan_test_ctrl: pattern request, chain drive/return and result.
// master = requester plus target chain, slave = the sequencer.
interface scan_test_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 4
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expect_in;
  logic                 chain_so;
  logic                 scan_en;
  logic                 scan_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] captured;
  logic [CHAIN_LEN-1:0] fail_bits;

  modport master (
    output start, pattern_in, expect_in, chain_so,
    input  scan_en, scan_in, busy, done, pass, captured, fail_bits
  );

  modport slave (
    input  start, pattern_in, expect_in, chain_so,
    output scan_en, scan_in, busy, done, pass, captured, fail_bits
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: loads one pattern MSB first, runs capture cycles,
// unloads the response and compares it against the expected vector.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN      = 4,
  parameter int unsigned CAPTURE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  scan_test_ctrl_if.slave bus
);

  localparam int unsigned MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAP   = CW'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
  typedef logic [CHAIN_LEN-1:0] vec_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          scan_en_q, scan_en_n;
  logic          scan_in_q, scan_in_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          pass_q, pass_n;
  vec_t          captured_q, captured_n;
  vec_t          fail_q, fail_n;
  vec_t          pat_q, pat_n;   // latched pattern, shifted left as bits go out
  vec_t          exp_q, exp_n;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= '0;
      fail_q     <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      scan_en_q  <= scan_en_n;
      scan_in_q  <= scan_in_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      pass_q     <= pass_n;
      captured_q <= captured_n;
      fail_q     <= fail_n;
      pat_q      <= pat_n;
      exp_q      <= exp_n;
    end
  end

  // Next state; outputs are computed for the state being entered
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    scan_en_n  = 1'b0;
    scan_in_n  = 1'b0;
    busy_n     = busy_q;
    done_n     = 1'b0;
    pass_n     = pass_q;
    captured_n = captured_q;
    fail_n     = fail_q;
    pat_n      = pat_q;
    exp_n      = exp_q;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (bus.start) begin
          state_n    = LOAD;
          pat_n      = bus.pattern_in << 1;
          exp_n      = bus.expect_in;
          captured_n = '0;
          pass_n     = 1'b0;
          fail_n     = '0;
          busy_n     = 1'b1;
          scan_en_n  = 1'b1;
          scan_in_n  = bus.pattern_in[CHAIN_LEN-1];
        end
      end

      LOAD: begin
        if (cnt == LAST_SHIFT) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          scan_en_n = 1'b1;
          scan_in_n = pat_q[CHAIN_LEN-1];
          pat_n     = pat_q << 1;
        end
      end

      CAPTURE: begin
        if (cnt == LAST_CAP) begin
          state_n   = UNLOAD;
          cnt_n     = '0;
          scan_en_n = 1'b1;
        end
      end

      UNLOAD: begin
        captured_n = {captured_q[CHAIN_LEN-2:0], bus.chain_so};
        if (cnt == LAST_SHIFT) begin
          state_n = DONE;
          cnt_n   = '0;
          done_n  = 1'b1;
          pass_n  = (captured_n == exp_q);
          fail_n  = captured_n ^ exp_q;
        end else begin
          scan_en_n = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.scan_en   = scan_en_q;
  assign bus.scan_in   = scan_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.captured  = captured_q;
  assign bus.fail_bits = fail_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: 4-flop and 8-flop chain models, directed and random patterns
// checked against a per-cycle expectation derived from the load/capture/unload rules.
module tb_scan_test_ctrl;

  logic clk;
  logic rst4, rst8;
  int   checks, errors;

  logic       sel;        // 0: 4-flop DUT, 1: 8-flop DUT
  logic       cap_mode;   // 4-flop chain captures cap_val when scan_en is low
  logic [3:0] cap_val;
  logic [7:0] last_res, last_exp;

  scan_test_ctrl_if #(.CHAIN_LEN(4)) i4 ();
  scan_test_ctrl_if #(.CHAIN_LEN(8)) i8 ();

  scan_test_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(1)) dut4 (.clk(clk), .rst(rst4), .bus(i4));
  scan_test_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(2)) dut8 (.clk(clk), .rst(rst8), .bus(i8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target chain models
  logic [3:0] ch4 = '0;
  logic [7:0] ch8 = '0;
  always @(posedge clk) begin
    if (i4.scan_en)    ch4 <= {ch4[2:0], i4.scan_in};
    else if (cap_mode) ch4 <= cap_val;
    if (i8.scan_en)    ch8 <= {ch8[6:0], i8.scan_in};
  end
  assign i4.chain_so = ch4[3];
  assign i8.chain_so = ch8[7];

  wire       m_en   = sel ? i8.scan_en : i4.scan_en;
  wire       m_si   = sel ? i8.scan_in : i4.scan_in;
  wire       m_busy = sel ? i8.busy    : i4.busy;
  wire       m_done = sel ? i8.done    : i4.done;
  wire       m_pass = sel ? i8.pass    : i4.pass;
  wire [7:0] m_cap  = sel ? i8.captured  : {4'b0, i4.captured};
  wire [7:0] m_fail = sel ? i8.fail_bits : {4'b0, i4.fail_bits};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exv);
    checks++;
    assert (obs === exv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
    end
  endtask

  task automatic set_start(input logic s, input logic [7:0] p, input logic [7:0] e);
    if (sel) begin
      i8.start = s; i8.pattern_in = p; i8.expect_in = e;
    end else begin
      i4.start = s; i4.pattern_in = p[3:0]; i4.expect_in = e[3:0];
    end
  endtask

  function automatic logic [7:0] mask();
    return sel ? 8'hFF : 8'h0F;
  endfunction

  // Response the chain hands back: loopback returns the pattern, capture mode the capture value
  function automatic logic [7:0] model_res(input logic [7:0] p);
    return (!sel && cap_mode) ? {4'b0, cap_val} : (p & mask());
  endfunction

  // One pattern, called at a negedge; returns at the negedge of the IDLE cycle after DONE
  task automatic run(input logic [7:0] pat_raw, input logic [7:0] exp_raw, input int glitch_j);
    int         cl, cc, last;
    logic [7:0] pat, exv, res;
    cl   = sel ? 8 : 4;
    cc   = sel ? 2 : 1;
    last = 2 * cl + cc;
    pat  = pat_raw & mask();
    exv  = exp_raw & mask();
    res  = model_res(pat);
    set_start(1'b1, pat, exv);
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j <= last + 1; j++) begin
      if (j > 0) @(negedge clk);
      if (j == glitch_j) set_start(1'b1, ~pat, ~exv);
      else               set_start(1'b0, 8'($urandom), 8'($urandom));
      chk($sformatf("scan_en c%0d", j), 8'(m_en), 8'((j < cl) || (j >= cl + cc && j < last)));
      chk($sformatf("scan_in c%0d", j), 8'(m_si), 8'((j < cl) ? pat[cl-1-j] : 1'b0));
      chk($sformatf("busy c%0d", j),    8'(m_busy), 8'(j <= last));
      chk($sformatf("done c%0d", j),    8'(m_done), 8'(j == last));
      if (j == last) begin
        chk("captured", m_cap, res);
        chk("pass", 8'(m_pass), 8'(res == exv));
        chk("fail_bits", m_fail, res ^ exv);
      end
    end
    set_start(1'b0, 8'h00, 8'h00);
    last_res = res;
    last_exp = exv;
  endtask

  // Idle cycles: result must stay put with no stray activity
  task automatic hold_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("hold done", 8'(m_done), 8'd0);
      chk("hold busy", 8'(m_busy), 8'd0);
      chk("hold scan_en", 8'(m_en), 8'd0);
      chk("hold captured", m_cap, last_res);
      chk("hold pass", 8'(m_pass), 8'(last_res == last_exp));
      chk("hold fail_bits", m_fail, last_res ^ last_exp);
    end
  endtask

  task automatic reset_state_check(input string tag);
    chk({tag, " scan_en"}, 8'(m_en), 8'd0);
    chk({tag, " scan_in"}, 8'(m_si), 8'd0);
    chk({tag, " busy"}, 8'(m_busy), 8'd0);
    chk({tag, " done"}, 8'(m_done), 8'd0);
    chk({tag, " pass"}, 8'(m_pass), 8'd0);
    chk({tag, " captured"}, m_cap, 8'd0);
    chk({tag, " fail_bits"}, m_fail, 8'd0);
  endtask

  initial begin
    logic [7:0] p, e;
    checks   = 0;
    errors   = 0;
    sel      = 1'b0;
    cap_mode = 1'b0;
    cap_val  = 4'd0;
    rst4     = 1'b0;
    rst8     = 1'b0;
    i4.start = 1'b0; i4.pattern_in = '0; i4.expect_in = '0;
    i8.start = 1'b0; i8.pattern_in = '0; i8.expect_in = '0;

    repeat (2) @(negedge clk);
    sel = 1'b0; reset_state_check("reset4");
    sel = 1'b1; reset_state_check("reset8");
    rst4 = 1'b1;
    rst8 = 1'b1;
    @(negedge clk);

    // Loopback, matching expect
    sel = 1'b0;
    run(8'h0B, 8'h0B, -1);
    hold_check(2);

    // Capture the ALU ADD result 3+5
    cap_mode = 1'b1;
    cap_val  = 4'(3 + 5);
    run(8'h06, 8'h08, -1);
    run(8'h06, 8'h00, -1);
    hold_check(3);

    // Reset during the second LOAD cycle
    cap_mode = 1'b0;
    set_start(1'b1, 8'h0F, 8'h0F);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    reset_state_check("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst done", 8'(m_done), 8'd0);
      chk("midrst busy", 8'(m_busy), 8'd0);
    end
    rst4 = 1'b1;
    @(negedge clk);
    run(8'h05, 8'h05, -1);

    // Start pulse during UNLOAD is ignored; next start right after DONE accepted
    run(8'h0C, 8'h0C, 6);
    run(8'h03, 8'h03, -1);
    hold_check(1);

    // Random patterns, back-to-back
    for (int n = 0; n < 10; n++) begin
      cap_mode = 1'($urandom_range(0, 1));
      cap_val  = 4'($urandom);
      p        = 8'($urandom);
      e        = ($urandom_range(0, 1) != 0) ? model_res(p) : 8'($urandom);
      run(p, e, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
    end
    hold_check(1);

    // 8-flop chain, two capture cycles
    sel      = 1'b1;
    cap_mode = 1'b0;
    run(8'hA5, 8'hA5, -1);
    hold_check(2);
    for (int n = 0; n < 6; n++) begin
      p = 8'($urandom);
      e = ($urandom_range(0, 1) != 0) ? p : 8'($urandom);
      run(p, e, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 18)) : -1);
    end
    hold_check(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
